// File: rtl/scroll_display.sv
// scroll_display: rotates a nibble message across NUM_BANKS multiplexed 4-digit 7-segment banks.
// Optional blink blanking of the anodes is built only when SCROLL_BLINK_EN is defined.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_STOP | idle; scroll counter held at 0, step pulses rotate once
//   ST_RUN  | scrolling; one rotation per scroll tick
//   ST_HOLD | pause of HOLD_STEPS ticks after a full rotation, no rotation

module scroll_display #(
    parameter int NUM_BANKS    = 2,
    parameter int SCROLL_DIV   = 200000000,
    parameter int HOLD_STEPS   = 0,
    parameter int REFRESH_BITS = 20,
    parameter int BLINK_BIT    = 25,
    parameter logic [16*NUM_BANKS-1:0] INIT_MSG = (16*NUM_BANKS)'(32'h18830812)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     step,
    input  logic                     load_valid,
    input  logic [16*NUM_BANKS-1:0]  load_data,
    output logic                     load_ready,
    input  logic                     blink,
    output logic [7*NUM_BANKS-1:0]   a_to_g,
    output logic [4*NUM_BANKS-1:0]   an,
    output logic [1:0]               state
);

    localparam int W      = 16 * NUM_BANKS;
    localparam int SC_W   = $clog2(SCROLL_DIV);
    localparam int ROT_W  = $clog2(4 * NUM_BANKS);
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [SC_W-1:0]   SCROLL_LAST = SC_W'(SCROLL_DIV - 1);
    localparam logic [ROT_W-1:0]  ROT_LAST    = ROT_W'(4 * NUM_BANKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            msg_q, msg_d;
    logic [SC_W-1:0]         scroll_cnt_q, scroll_cnt_d;
    logic [ROT_W-1:0]        rot_cnt_q, rot_cnt_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [7*NUM_BANKS-1:0]  a_to_g_q, a_to_g_d;
    logic [4*NUM_BANKS-1:0]  an_q, an_d;

    logic         load_fire;
    logic         tick;
    logic [W-1:0] msg_rot;
    logic [1:0]   sel;

    assign load_ready = reset;
    assign load_fire  = load_valid & reset;
    assign tick       = (state_q != ST_STOP) && (scroll_cnt_q == SCROLL_LAST);
    assign msg_rot    = dir ? {msg_q[3:0], msg_q[W-1:4]} : {msg_q[W-5:0], msg_q[W-1:W-4]};
    assign sel        = refresh_q[REFRESH_BITS-1 -: 2];

    assign a_to_g = a_to_g_q;
    assign an     = an_q;
    assign state  = state_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        rot_cnt_d    = rot_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        scroll_cnt_d = '0;
        if (state_q != ST_STOP) begin
            scroll_cnt_d = tick ? '0 : scroll_cnt_q + 1'b1;
        end

        case (state_q)
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RUN;
                end
                if (step) begin
                    msg_d = msg_rot;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d      = ST_STOP;
                    scroll_cnt_d = '0;
                end else if (tick) begin
                    msg_d = msg_rot;
                    if (rot_cnt_q == ROT_LAST) begin
                        rot_cnt_d = '0;
                        if (HOLD_STEPS > 0) begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        rot_cnt_d = rot_cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!en) begin
                    state_d      = ST_STOP;
                    hold_cnt_d   = '0;
                    scroll_cnt_d = '0;
                end else if (tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d      = ST_STOP;
                scroll_cnt_d = '0;
            end
        endcase

        // A load overrides whatever the tick or step would have done this cycle.
        if (load_fire) begin
            msg_d        = load_data;
            rot_cnt_d    = '0;
            scroll_cnt_d = '0;
            hold_cnt_d   = '0;
            if (state_d == ST_HOLD) begin
                state_d = ST_RUN;
            end
        end
    end

    assign refresh_d = refresh_q + 1'b1;

`ifdef SCROLL_BLINK_EN
    logic [BLINK_BIT:0] blink_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = blink;
`endif

    always_comb begin
        a_to_g_d = '0;
        an_d     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            a_to_g_d[7*b +: 7] = seg_decode(msg_q[16*b + 4*int'(sel) +: 4]);
            an_d[4*b +: 4]     = 4'b0001 << sel;
        end
`ifdef SCROLL_BLINK_EN
        if (blink && blink_cnt_q[BLINK_BIT]) begin
            an_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_STOP;
            msg_q        <= INIT_MSG;
            scroll_cnt_q <= '0;
            rot_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            refresh_q    <= '0;
            a_to_g_q     <= '0;
            an_q         <= '0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            scroll_cnt_q <= scroll_cnt_d;
            rot_cnt_q    <= rot_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            refresh_q    <= refresh_d;
            a_to_g_q     <= a_to_g_d;
            an_q         <= an_d;
        end
    end

endmodule
